// File: rtl/bcd_clock_core.sv
// BCD hh:mm:ss timekeeper with 12/24-hour mode, debounced set buttons
// with hold-to-repeat, and one alarm channel.

module bcd_clock_btn #(
    parameter int DEB = 1_000_000,
    parameter int DLY = 50_000_000,
    parameter int PER = 10_000_000
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic btn,
    output logic inc
);

    localparam int DW = $clog2(DEB + 1);
    localparam int HMAX = (DLY > PER) ? DLY : PER;
    localparam int HW = $clog2(HMAX + 1);
    localparam logic [DW-1:0] DEB_M = DW'(DEB - 1);
    localparam logic [HW-1:0] DLY_M = HW'(DLY - 1);
    localparam logic [HW-1:0] PER_M = HW'(PER - 1);

    logic          s1, s2, lvl, lvl_q, blk, rep;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;

    // Synchronise, then accept a new level after DEB stable cycles.
    // Reset pretends the button is held so a press spanning reset is ignored.
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            lvl  <= 1'b1;
            dcnt <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            if (s2 == lvl) begin
                dcnt <= '0;
            end else if (dcnt == DEB_M) begin
                lvl  <= s2;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + DW'(1);
            end
        end
    end

    // One pulse per accepted press, then auto-repeat while held.
    // blk stays set until the level is seen low once.
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            lvl_q <= 1'b1;
            blk   <= 1'b1;
            rep   <= 1'b0;
            hcnt  <= '0;
            inc   <= 1'b0;
        end else begin
            lvl_q <= lvl;
            inc   <= 1'b0;
            if (!lvl) begin
                blk  <= 1'b0;
                rep  <= 1'b0;
                hcnt <= '0;
            end else if (blk) begin
                hcnt <= '0;
            end else if (!lvl_q) begin
                inc  <= 1'b1;
                rep  <= 1'b0;
                hcnt <= '0;
            end else if (hcnt == (rep ? PER_M : DLY_M)) begin
                inc  <= 1'b1;
                rep  <= 1'b1;
                hcnt <= '0;
            end else begin
                hcnt <= hcnt + HW'(1);
            end
        end
    end

endmodule

module bcd_clock_core #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int MODE_24H     = 0,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int REPEAT_DLY   = 50_000_000,
    parameter int REPEAT_PER   = 10_000_000,
    parameter int ALARM_SEC    = 30
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       inc_hr,
    input  logic       inc_min,
    input  logic       set_alarm,
    input  logic       alarm_en,
    output logic [3:0] hr_10s,
    output logic [3:0] hr_1s,
    output logic [3:0] min_10s,
    output logic [3:0] min_1s,
    output logic [3:0] sec_10s,
    output logic [3:0] sec_1s,
    output logic       am_pm,
    output logic       o_1Hz,
    output logic       alarm_hit,
    output logic       day_tick
);

    localparam int PW = $clog2(CLK_HZ + 1);
    localparam int AW = $clog2(ALARM_SEC + 1);
    localparam logic [PW-1:0] CNT_MAX  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] CNT_HALF = PW'(CLK_HZ / 2);
    localparam logic [AW-1:0] AL_MAX   = AW'(ALARM_SEC - 1);
    localparam logic [7:0]    HR_RST   = (MODE_24H != 0) ? 8'h00 : 8'h12;

    logic          p_hr, p_min;
    logic [PW-1:0] cnt, cnt_n;
    logic [7:0]    t_h, t_m, t_s, t_h_n, t_m_n, t_s_n;
    logic [7:0]    al_h, al_m, al_h_n, al_m_n;
    logic          t_pm, t_pm_n, al_pm, al_pm_n;
    logic          pend, pend_n, hit_n, o_1Hz_n;
    logic [AW-1:0] acnt, acnt_n;
    logic          sec_tick, tick, man_t, adv, roll, match;
    logic [7:0]    d_h, d_m, d_s;
    logic          d_pm;

    // Hour advance, returns {am_pm, hour}.
    function automatic logic [8:0] hr_next(input logic [7:0] h,
                                           input logic pm);
        logic [7:0] nh;
        logic       npm;
        if (MODE_24H != 0) begin
            if (h == 8'h23)
                nh = 8'h00;
            else if (h[3:0] == 4'd9)
                nh = {h[7:4] + 4'd1, 4'd0};
            else
                nh = h + 8'd1;
            npm = (nh >= 8'h12);
        end else begin
            if (h == 8'h12)
                nh = 8'h01;
            else if (h == 8'h09)
                nh = 8'h10;
            else
                nh = h + 8'd1;
            npm = (h == 8'h11) ? ~pm : pm;
        end
        return {npm, nh};
    endfunction

    // Two-digit BCD 00..59 advance.
    function automatic logic [7:0] m60_next(input logic [7:0] v);
        if (v == 8'h59)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return v + 8'd1;
    endfunction

    bcd_clock_btn #(
        .DEB(DEBOUNCE_CYC),
        .DLY(REPEAT_DLY),
        .PER(REPEAT_PER)
    ) u_btn_hr (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .btn       (inc_hr),
        .inc       (p_hr)
    );

    bcd_clock_btn #(
        .DEB(DEBOUNCE_CYC),
        .DLY(REPEAT_DLY),
        .PER(REPEAT_PER)
    ) u_btn_min (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .btn       (inc_min),
        .inc       (p_min)
    );

    // Next-state for prescaler, time, alarm and display.
    // A manual time edit pre-empts the tick, which is kept pending.
    always_comb begin
        sec_tick = (cnt == CNT_MAX);
        cnt_n    = sec_tick ? '0 : cnt + PW'(1);
        o_1Hz_n  = (cnt_n < CNT_HALF);
        tick     = sec_tick | pend;
        man_t    = ~set_alarm & (p_hr | p_min);
        adv      = tick & ~man_t;
        pend_n   = tick & man_t;
        t_h_n    = t_h;
        t_m_n    = t_m;
        t_s_n    = t_s;
        t_pm_n   = t_pm;
        al_h_n   = al_h;
        al_m_n   = al_m;
        al_pm_n  = al_pm;
        roll     = 1'b0;
        if (man_t) begin
            if (p_min)
                t_m_n = m60_next(t_m);
            if (p_hr)
                {t_pm_n, t_h_n} = hr_next(t_h, t_pm);
        end else if (tick) begin
            t_s_n = m60_next(t_s);
            if (t_s == 8'h59) begin
                t_m_n = m60_next(t_m);
                if (t_m == 8'h59) begin
                    {t_pm_n, t_h_n} = hr_next(t_h, t_pm);
                    if (MODE_24H != 0)
                        roll = (t_h == 8'h23);
                    else
                        roll = (t_h == 8'h11) & t_pm;
                end
            end
        end
        if (set_alarm) begin
            if (p_min)
                al_m_n = m60_next(al_m);
            if (p_hr)
                {al_pm_n, al_h_n} = hr_next(al_h, al_pm);
        end
        match = adv & alarm_en & (t_s_n == 8'h00) &
                (t_m_n == al_m) & (t_h_n == al_h) &
                (t_pm_n == al_pm);
        hit_n  = alarm_hit;
        acnt_n = acnt;
        if (!alarm_en) begin
            hit_n  = 1'b0;
            acnt_n = '0;
        end else if (match) begin
            hit_n  = 1'b1;
            acnt_n = '0;
        end else if (alarm_hit && adv) begin
            if (acnt == AL_MAX) begin
                hit_n  = 1'b0;
                acnt_n = '0;
            end else begin
                acnt_n = acnt + AW'(1);
            end
        end
        d_h  = set_alarm ? al_h_n  : t_h_n;
        d_m  = set_alarm ? al_m_n  : t_m_n;
        d_s  = set_alarm ? 8'h00   : t_s_n;
        d_pm = set_alarm ? al_pm_n : t_pm_n;
    end

    // State and registered outputs.
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            cnt       <= '0;
            t_h       <= HR_RST;
            t_m       <= 8'h00;
            t_s       <= 8'h00;
            t_pm      <= 1'b0;
            al_h      <= HR_RST;
            al_m      <= 8'h00;
            al_pm     <= 1'b0;
            pend      <= 1'b0;
            acnt      <= '0;
            alarm_hit <= 1'b0;
            day_tick  <= 1'b0;
            o_1Hz     <= 1'b1;
            hr_10s    <= HR_RST[7:4];
            hr_1s     <= HR_RST[3:0];
            min_10s   <= 4'd0;
            min_1s    <= 4'd0;
            sec_10s   <= 4'd0;
            sec_1s    <= 4'd0;
            am_pm     <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            t_h       <= t_h_n;
            t_m       <= t_m_n;
            t_s       <= t_s_n;
            t_pm      <= t_pm_n;
            al_h      <= al_h_n;
            al_m      <= al_m_n;
            al_pm     <= al_pm_n;
            pend      <= pend_n;
            acnt      <= acnt_n;
            alarm_hit <= hit_n;
            day_tick  <= adv & roll;
            o_1Hz     <= o_1Hz_n;
            hr_10s    <= d_h[7:4];
            hr_1s     <= d_h[3:0];
            min_10s   <= d_m[7:4];
            min_1s    <= d_m[3:0];
            sec_10s   <= d_s[7:4];
            sec_1s    <= d_s[3:0];
            am_pm     <= d_pm;
        end
    end

endmodule

// File: tb/tb_bcd_clock_core.sv
// Bench for bcd_clock_core: 12h and 24h instances, scoreboard of
// cycle-stamped expectations checked by an independent monitor.

module tb_bcd_clock_core;

    logic clk_100MHz = 1'b0;
    logic reset      = 1'b0;
    logic inc_hr     = 1'b0;
    logic inc_min    = 1'b0;
    logic set_alarm  = 1'b0;
    logic alarm_en   = 1'b0;

    logic [3:0] ha10, ha1, ma10, ma1, sa10, sa1;
    logic [3:0] hb10, hb1, mb10, mb1, sb10, sb1;
    logic       pm_a, hz_a, hit_a, dt_a;
    logic       pm_b, hz_b, hit_b, dt_b;

    bcd_clock_core #(
        .CLK_HZ(10), .MODE_24H(0), .DEBOUNCE_CYC(3),
        .REPEAT_DLY(20), .REPEAT_PER(5), .ALARM_SEC(2)
    ) u_a (
        .clk_100MHz(clk_100MHz), .reset(reset),
        .inc_hr(inc_hr), .inc_min(inc_min),
        .set_alarm(set_alarm), .alarm_en(alarm_en),
        .hr_10s(ha10), .hr_1s(ha1), .min_10s(ma10), .min_1s(ma1),
        .sec_10s(sa10), .sec_1s(sa1), .am_pm(pm_a), .o_1Hz(hz_a),
        .alarm_hit(hit_a), .day_tick(dt_a)
    );

    bcd_clock_core #(
        .CLK_HZ(10), .MODE_24H(1), .DEBOUNCE_CYC(3),
        .REPEAT_DLY(20), .REPEAT_PER(5), .ALARM_SEC(2)
    ) u_b (
        .clk_100MHz(clk_100MHz), .reset(reset),
        .inc_hr(inc_hr), .inc_min(inc_min),
        .set_alarm(set_alarm), .alarm_en(alarm_en),
        .hr_10s(hb10), .hr_1s(hb1), .min_10s(mb10), .min_1s(mb1),
        .sec_10s(sb10), .sec_1s(sb1), .am_pm(pm_b), .o_1Hz(hz_b),
        .alarm_hit(hit_b), .day_tick(dt_b)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int cyc = 0;
    always @(posedge clk_100MHz) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    localparam int K_TA  = 0;
    localparam int K_TB  = 1;
    localparam int K_HIT = 2;
    localparam int K_HZ  = 3;
    localparam int K_DCA = 4;
    localparam int K_DCB = 5;
    localparam int K_DT  = 6;

    chk_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   t0 = 0;
    int   dc_a = 0;
    int   dc_b = 0;

    function automatic logic [31:0] tw(int h, int m, int s, bit pm);
        return {7'd0, pm, 4'(h / 10), 4'(h % 10), 4'(m / 10),
                4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [31:0] obs(int k);
        case (k)
            K_TA:  return {7'd0, pm_a, ha10, ha1, ma10, ma1, sa10, sa1};
            K_TB:  return {7'd0, pm_b, hb10, hb1, mb10, mb1, sb10, sb1};
            K_HIT: return {31'd0, hit_a};
            K_HZ:  return {31'd0, hz_a};
            K_DCA: return 32'(dc_a);
            K_DCB: return 32'(dc_b);
            K_DT:  return {31'd0, dt_a};
            default: return '1;
        endcase
    endfunction

    task automatic chk(int j, int kind, logic [31:0] e, string nm);
        chk_t c;
        c.cyc  = t0 + j;
        c.kind = kind;
        c.exp  = e;
        c.name = nm;
        sb.push_back(c);
    endtask

    task automatic wait_to(int j);
        while (cyc < t0 + j) @(negedge clk_100MHz);
    endtask

    task automatic press(int which, int k, int hold);
        wait_to(k - 1);
        if (which == 0) inc_hr = 1'b1;
        else            inc_min = 1'b1;
        wait_to(k - 1 + hold);
        inc_hr  = 1'b0;
        inc_min = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_100MHz);
        reset     = 1'b0;
        inc_hr    = 1'b0;
        inc_min   = 1'b0;
        set_alarm = 1'b0;
        alarm_en  = 1'b0;
        @(negedge clk_100MHz);
        @(negedge clk_100MHz);
        reset = 1'b1;
        t0    = cyc;
    endtask

    // Monitor: count day_tick pulses and retire due expectations.
    always @(negedge clk_100MHz) begin
        chk_t        c;
        logic [31:0] got;
        if (!reset) begin
            dc_a = 0;
            dc_b = 0;
        end else begin
            if (dt_a) dc_a++;
            if (dt_b) dc_b++;
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            c   = sb.pop_front();
            got = obs(c.kind);
            n_vec++;
            if (c.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s: check missed, now cycle %0d, due %0d",
                         c.name, cyc, c.cyc);
            end else if (got !== c.exp) begin
                n_bad++;
                $display("FAIL %s: got %h, expected %h",
                         c.name, got, c.exp);
            end
        end
    end

    initial begin
        // Reset state, free running to 12:01:00, blink output.
        do_reset();
        chk(1, K_TA, tw(12, 0, 0, 0), "rst_time12");
        chk(1, K_TB, tw(0, 0, 0, 0), "rst_time24");
        chk(1, K_HIT, 0, "rst_hit");
        chk(1, K_DT, 0, "rst_daytick");
        chk(4, K_HZ, 1, "hz_c4");
        chk(5, K_HZ, 0, "hz_c5");
        chk(9, K_HZ, 0, "hz_c9");
        chk(10, K_HZ, 1, "hz_c10");
        chk(10, K_TA, tw(12, 0, 1, 0), "first_sec");
        chk(599, K_TA, tw(12, 0, 59, 0), "t_0059");
        chk(600, K_TA, tw(12, 1, 0, 0), "t_0100");
        chk(600, K_TB, tw(0, 1, 0, 0), "t24_0100");
        chk(600, K_DCA, 0, "no_daytick");
        wait_to(600);

        // Preload 11:59 PM / 23:59 by repeat bursts, then midnight.
        do_reset();
        chk(40, K_TA, tw(2, 0, 4, 0), "hr_burst_early");
        chk(40, K_TB, tw(2, 0, 4, 0), "hr_burst_early24");
        chk(595, K_TA, tw(11, 59, 59, 1), "pre_midnight");
        chk(595, K_TB, tw(23, 59, 59, 1), "pre_midnight24");
        chk(599, K_DCA, 0, "dt_before");
        chk(599, K_DCB, 0, "dt_before24");
        chk(600, K_TA, tw(12, 0, 0, 0), "midnight");
        chk(600, K_TB, tw(0, 0, 0, 0), "midnight24");
        chk(600, K_DT, 1, "dt_high");
        chk(601, K_DT, 0, "dt_one_cycle");
        chk(650, K_DCA, 1, "dt_count");
        chk(650, K_DCB, 1, "dt_count24");
        press(0, 10, 128);
        press(1, 150, 308);
        wait_to(650);

        // Hold-to-repeat: 1 + 4 increments, then a 2-cycle glitch.
        do_reset();
        chk(20, K_TA, tw(12, 1, 2, 0), "rep_first");
        chk(40, K_TA, tw(12, 2, 4, 0), "rep_second");
        chk(60, K_TA, tw(12, 5, 6, 0), "rep_total");
        chk(60, K_TB, tw(0, 5, 6, 0), "rep_total24");
        chk(95, K_TA, tw(12, 5, 9, 0), "glitch");
        chk(95, K_TB, tw(0, 5, 9, 0), "glitch24");
        press(1, 12, 38);
        press(1, 72, 2);
        wait_to(95);

        // Minute pulse on the tick cycle at 12:00:07.
        do_reset();
        chk(79, K_TA, tw(12, 0, 7, 0), "coll_before");
        chk(80, K_TA, tw(12, 1, 7, 0), "coll_manual");
        chk(81, K_TA, tw(12, 1, 8, 0), "coll_pending");
        chk(85, K_TA, tw(12, 1, 8, 0), "coll_hold");
        chk(90, K_TA, tw(12, 1, 9, 0), "coll_next");
        press(1, 74, 8);
        wait_to(90);

        // Alarm at 12:02 AM, full duration.
        do_reset();
        set_alarm = 1'b1;
        chk(20, K_TA, tw(12, 1, 0, 0), "al_disp1");
        chk(20, K_TB, tw(0, 1, 0, 0), "al_disp1_24");
        chk(60, K_TA, tw(12, 2, 0, 0), "al_disp2");
        chk(75, K_TA, tw(12, 0, 7, 0), "al_time_kept");
        chk(1195, K_TA, tw(12, 1, 59, 0), "al_pre");
        chk(1199, K_HIT, 0, "hit_before");
        chk(1200, K_TA, tw(12, 2, 0, 0), "al_match_time");
        chk(1200, K_HIT, 1, "hit_rise");
        chk(1219, K_HIT, 1, "hit_hold");
        chk(1220, K_HIT, 0, "hit_expire");
        press(1, 10, 8);
        press(1, 40, 8);
        wait_to(70);
        set_alarm = 1'b0;
        alarm_en  = 1'b1;
        wait_to(1220);

        // Alarm at 12:01 AM, cleared by alarm_en.
        do_reset();
        set_alarm = 1'b1;
        chk(599, K_HIT, 0, "hit2_before");
        chk(600, K_HIT, 1, "hit2_rise");
        chk(605, K_HIT, 1, "hit2_hold");
        chk(606, K_HIT, 0, "hit2_disarm");
        chk(650, K_HIT, 0, "hit2_stays_off");
        press(1, 10, 8);
        wait_to(70);
        set_alarm = 1'b0;
        alarm_en  = 1'b1;
        wait_to(605);
        alarm_en = 1'b0;
        wait_to(650);

        // Reset during an hour repeat burst with the button held.
        do_reset();
        chk(54, K_TA, tw(5, 0, 5, 0), "burst_hr");
        chk(54, K_TB, tw(5, 0, 5, 0), "burst_hr24");
        chk(56, K_TA, tw(12, 0, 0, 0), "mid_reset");
        chk(56, K_TB, tw(0, 0, 0, 0), "mid_reset24");
        wait_to(11);
        inc_hr = 1'b1;
        wait_to(55);
        reset = 1'b0;
        wait_to(56);
        reset = 1'b1;
        t0    = cyc;
        chk(75, K_TA, tw(12, 0, 7, 0), "held_no_inc");
        chk(110, K_TA, tw(1, 0, 11, 0), "repress");
        chk(110, K_TB, tw(1, 0, 11, 0), "repress24");
        wait_to(80);
        inc_hr = 1'b0;
        press(0, 100, 8);
        wait_to(110);

        for (int i = 0; i < 200 && sb.size() > 0; i++)
            @(negedge clk_100MHz);
        while (sb.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: never reached, due cycle %0d",
                     sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
